// File: rtl/arp_resolver.sv
// ARP resolver: maps a next-hop IPv4 address to a destination MAC through a small
// fully-associative cache. Handles broadcast and gateway resolution, and on a miss
// issues who-has queries with timeout and retry. Replies seen from the parser are
// learned into the cache in any state.
module arp_resolver #(
    parameter int unsigned CACHE_ENTRIES       = 4,
    parameter int unsigned REQUEST_RETRY_COUNT = 3,
    parameter logic [15:0] REQUEST_TIMEOUT     = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        query_valid,
    input  logic        query_ready,
    output logic [31:0] query_target_ip,
    input  logic        rx_reply_valid,
    input  logic [31:0] rx_sender_ip,
    input  logic [47:0] rx_sender_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,
    input  logic        clear_cache,
    output logic        busy
);

    localparam int unsigned IdxW     = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
    localparam logic [3:0]  RetryMax = 4'(REQUEST_RETRY_COUNT);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StQuery,
        StWaitReply,
        StRespond
    } state_e;

    state_e      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [47:0] r_resp_mac;
    logic        r_query_valid;
    logic [31:0] r_query_ip;
    logic [31:0] r_target;
    logic        r_bcast;
    logic [15:0] r_timer;
    logic [3:0]  r_retry;

    logic [31:0]              r_cache_ip  [CACHE_ENTRIES];
    logic [47:0]              r_cache_mac [CACHE_ENTRIES];
    logic [CACHE_ENTRIES-1:0] r_cache_vld;
    logic [IdxW-1:0]          r_repl_ptr;

    logic            w_on_subnet;
    logic            w_bcast;
    logic            w_hit;
    logic [47:0]     w_hit_mac;
    logic            w_learn;
    logic            w_learn_match;
    logic [IdxW-1:0] w_learn_idx;
    logic [IdxW-1:0] w_learn_slot;
    logic            w_reply_match;

    // Address classification of the incoming request, using live configuration.
    assign w_on_subnet = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
    assign w_bcast     = (arp_request_ip == 32'hFFFF_FFFF) ||
                         (((arp_request_ip & ~subnet_mask) == ~subnet_mask) && w_on_subnet);

    // Only unicast senders with a real address are worth remembering.
    assign w_learn       = rx_reply_valid && (rx_sender_ip != 32'd0) && !rx_sender_mac[40];
    assign w_learn_slot  = w_learn_match ? w_learn_idx : r_repl_ptr;
    assign w_reply_match = rx_reply_valid && (rx_sender_ip == r_target);

    // Associative search: target lookup and learn-address match.
    always_comb begin
        w_hit         = 1'b0;
        w_hit_mac     = 48'd0;
        w_learn_match = 1'b0;
        w_learn_idx   = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (r_cache_vld[i] && (r_cache_ip[i] == r_target)) begin
                w_hit     = 1'b1;
                w_hit_mac = r_cache_mac[i];
            end
            if (r_cache_vld[i] && (r_cache_ip[i] == rx_sender_ip)) begin
                w_learn_match = 1'b1;
                w_learn_idx   = IdxW'(i);
            end
        end
    end

    // Cache storage: clear first, so a same-cycle learn survives for its own entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache_vld <= '0;
            r_repl_ptr  <= '0;
        end else begin
            if (clear_cache) begin
                r_cache_vld <= '0;
            end
            if (w_learn) begin
                r_cache_vld[w_learn_slot] <= 1'b1;
                r_cache_ip[w_learn_slot]  <= rx_sender_ip;
                r_cache_mac[w_learn_slot] <= rx_sender_mac;
                if (!w_learn_match) begin
                    r_repl_ptr <= r_repl_ptr + IdxW'(1);
                end
            end
        end
    end

    // Resolution FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_req_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_error  <= 1'b0;
            r_resp_mac    <= 48'd0;
            r_query_valid <= 1'b0;
            r_query_ip    <= 32'd0;
            r_target      <= 32'd0;
            r_bcast       <= 1'b0;
            r_timer       <= 16'd0;
            r_retry       <= 4'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (arp_request_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_bcast     <= w_bcast;
                        r_target    <= (w_bcast || w_on_subnet) ? arp_request_ip : gateway_ip;
                        r_state     <= StLookup;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                StLookup: begin
                    if (r_bcast || w_hit) begin
                        r_resp_mac   <= r_bcast ? 48'hFFFF_FFFF_FFFF : w_hit_mac;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StRespond;
                    end else begin
                        r_retry       <= 4'd0;
                        r_query_valid <= 1'b1;
                        r_query_ip    <= r_target;
                        r_state       <= StQuery;
                    end
                end
                StQuery: begin
                    if (query_ready) begin
                        r_query_valid <= 1'b0;
                        r_timer       <= REQUEST_TIMEOUT;
                        if (r_retry != 4'hF) begin
                            r_retry <= r_retry + 4'd1;
                        end
                        r_state <= StWaitReply;
                    end
                end
                StWaitReply: begin
                    if (w_reply_match) begin
                        r_resp_mac   <= rx_sender_mac;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StRespond;
                    end else if (r_timer <= 16'd1) begin
                        // Timer hits zero on this edge.
                        r_timer <= 16'd0;
                        if (r_retry < RetryMax) begin
                            r_query_valid <= 1'b1;
                            r_state       <= StQuery;
                        end else begin
                            r_resp_mac   <= 48'd0;
                            r_resp_error <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= StRespond;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                StRespond: begin
                    if (arp_response_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign arp_request_ready  = r_req_ready;
    assign arp_response_valid = r_resp_valid;
    assign arp_response_error = r_resp_error;
    assign arp_response_mac   = r_resp_mac;
    assign query_valid        = r_query_valid;
    assign query_target_ip    = r_query_ip;
    assign busy               = (r_state != StIdle);

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: miss/hit, gateway, broadcast, timeout/retry,
// query backpressure, round-robin replacement, cache clear and mid-operation reset.
module tb_arp_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        query_valid;
    logic        query_ready;
    logic [31:0] query_target_ip;
    logic        rx_reply_valid;
    logic [31:0] rx_sender_ip;
    logic [47:0] rx_sender_mac;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;
    logic        clear_cache;
    logic        busy;

    always #5 clk = ~clk;

    arp_resolver #(
        .CACHE_ENTRIES       (4),
        .REQUEST_RETRY_COUNT (3),
        .REQUEST_TIMEOUT     (16'd20)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .arp_request_valid  (arp_request_valid),
        .arp_request_ready  (arp_request_ready),
        .arp_request_ip     (arp_request_ip),
        .arp_response_valid (arp_response_valid),
        .arp_response_ready (arp_response_ready),
        .arp_response_error (arp_response_error),
        .arp_response_mac   (arp_response_mac),
        .query_valid        (query_valid),
        .query_ready        (query_ready),
        .query_target_ip    (query_target_ip),
        .rx_reply_valid     (rx_reply_valid),
        .rx_sender_ip       (rx_sender_ip),
        .rx_sender_mac      (rx_sender_mac),
        .local_ip           (local_ip),
        .gateway_ip         (gateway_ip),
        .subnet_mask        (subnet_mask),
        .clear_cache        (clear_cache),
        .busy               (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Free-running cycle counter and query-handshake monitor.
    int          cyc = 0;
    int          q_count = 0;
    int          hs_cyc [64];
    logic [31:0] q_last_ip = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && query_valid && query_ready) begin
            if (q_count < 64) hs_cyc[q_count] <= cyc;
            q_count   <= q_count + 1;
            q_last_ip <= query_target_ip;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_request(input logic [31:0] ip, output int acc_cyc);
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        for (int i = 0; i < 50; i++) begin
            if (arp_request_ready) break;
            tick();
        end
        check("req_ready", {63'd0, arp_request_ready}, 64'd1);
        acc_cyc = cyc;
        tick();
        arp_request_valid = 1'b0;
    endtask

    task automatic take_response(input string tag, output logic [47:0] mac, output logic err);
        for (int i = 0; i < 200; i++) begin
            if (arp_response_valid) break;
            tick();
        end
        check({tag, "_rsp_valid"}, {63'd0, arp_response_valid}, 64'd1);
        mac = arp_response_mac;
        err = arp_response_error;
        arp_response_ready = 1'b1;
        tick();
        arp_response_ready = 1'b0;
    endtask

    task automatic send_reply(input logic [31:0] ip, input logic [47:0] mac);
        rx_reply_valid = 1'b1;
        rx_sender_ip   = ip;
        rx_sender_mac  = mac;
        tick();
        rx_reply_valid = 1'b0;
    endtask

    // One full resolution; a query (if any) is answered from reply_ip/reply_mac.
    task automatic resolve(input string tag, input logic [31:0] ip, input logic [31:0] reply_ip,
                           input logic [47:0] reply_mac, input logic exp_hit,
                           input logic [47:0] exp_mac);
        int          q0;
        int          acc;
        logic [47:0] mac;
        logic        err;
        q0 = q_count;
        send_request(ip, acc);
        for (int i = 0; i < 20; i++) begin
            if (arp_response_valid || q_count != q0) break;
            tick();
        end
        check({tag, "_hit"}, {63'd0, (q_count == q0)}, {63'd0, exp_hit});
        if (q_count != q0) begin
            check({tag, "_qip"}, {32'd0, q_last_ip}, {32'd0, reply_ip});
            send_reply(reply_ip, reply_mac);
        end
        take_response(tag, mac, err);
        check({tag, "_mac"}, {16'd0, mac}, {16'd0, exp_mac});
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          q0;
        int          acc;
        int          lat;
        int          stable;
        logic [47:0] mac;
        logic        err;
        logic [47:0] mac_base;

        rst                = 1'b1;
        arp_request_valid  = 1'b0;
        arp_request_ip     = 32'd0;
        arp_response_ready = 1'b0;
        query_ready        = 1'b1;
        rx_reply_valid     = 1'b0;
        rx_sender_ip       = 32'd0;
        rx_sender_mac      = 48'd0;
        local_ip           = 32'hC0A8_0180;
        gateway_ip         = 32'hC0A8_0101;
        subnet_mask        = 32'hFFFF_FF00;
        clear_cache        = 1'b0;
        mac_base           = 48'h0200_0000_0000;
        tick(); tick(); tick();

        check("rst_ctrl", {59'd0, arp_request_ready, arp_response_valid, arp_response_error,
                           query_valid, busy}, 64'd0);
        check("rst_mac", {16'd0, arp_response_mac}, 64'd0);
        check("rst_qip", {32'd0, query_target_ip}, 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {63'd0, arp_request_ready}, 64'd1);

        // Miss, then the same address hits with two-cycle latency and no query.
        resolve("miss1", 32'hC0A8_0105, 32'hC0A8_0105, 48'h0011_2233_4455, 1'b0,
                48'h0011_2233_4455);
        q0 = q_count;
        send_request(32'hC0A8_0105, acc);
        for (int i = 0; i < 10; i++) begin
            if (arp_response_valid) break;
            tick();
        end
        lat = cyc - acc;
        check("hit_latency", 64'(lat), 64'd2);
        check("hit_noquery", 64'(q_count - q0), 64'd0);
        take_response("hit1", mac, err);
        check("hit1_mac", {16'd0, mac}, {16'd0, 48'h0011_2233_4455});

        // Off-subnet goes through the gateway.
        resolve("gw", 32'h0808_0808, 32'hC0A8_0101, 48'h0A0B_0C0D_0E0F, 1'b0, 48'h0A0B_0C0D_0E0F);

        // Broadcasts never query.
        resolve("bc_all", 32'hFFFF_FFFF, 32'd0, 48'd0, 1'b1, 48'hFFFF_FFFF_FFFF);
        resolve("bc_net", 32'hC0A8_01FF, 32'd0, 48'd0, 1'b1, 48'hFFFF_FFFF_FFFF);

        // No reply: three queries spaced by the timeout, then an error.
        q0 = q_count;
        send_request(32'hC0A8_0177, acc);
        take_response("tmo", mac, err);
        check("tmo_queries", 64'(q_count - q0), 64'd3);
        lat = hs_cyc[q0 + 1] - hs_cyc[q0];
        check("tmo_gap1", {63'd0, (lat >= 18 && lat <= 24)}, 64'd1);
        lat = hs_cyc[q0 + 2] - hs_cyc[q0 + 1];
        check("tmo_gap2", {63'd0, (lat >= 18 && lat <= 24)}, 64'd1);
        check("tmo_err", {63'd0, err}, 64'd1);
        check("tmo_mac", {16'd0, mac}, 64'd0);

        // Query backpressure: command must hold steady.
        query_ready = 1'b0;
        q0 = q_count;
        send_request(32'hC0A8_0142, acc);
        for (int i = 0; i < 10; i++) begin
            if (query_valid) break;
            tick();
        end
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (query_valid && query_target_ip == 32'hC0A8_0142) stable++;
            tick();
        end
        check("bp_stable", 64'(stable), 64'd10);
        query_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (q_count != q0) break;
            tick();
        end
        check("bp_handshake", 64'(q_count - q0), 64'd1);
        send_reply(32'hC0A8_0142, 48'h0200_0000_0042);
        take_response("bp", mac, err);
        check("bp_mac", {16'd0, mac}, {16'd0, 48'h0200_0000_0042});

        // Five learns into four entries evict the first one.
        for (int k = 0; k < 5; k++) begin
            send_reply(32'hC0A8_0110 + 32'(k), mac_base + 48'(16 + k));
        end
        for (int k = 1; k < 5; k++) begin
            resolve("rr_hit", 32'hC0A8_0110 + 32'(k), 32'hC0A8_0110 + 32'(k),
                    mac_base + 48'(16 + k), 1'b1, mac_base + 48'(16 + k));
        end
        resolve("rr_evicted", 32'hC0A8_0110, 32'hC0A8_0110, mac_base + 48'd16, 1'b0,
                mac_base + 48'd16);

        // Clear invalidates everything.
        clear_cache = 1'b1;
        tick();
        clear_cache = 1'b0;
        for (int k = 2; k < 5; k++) begin
            resolve("clr_miss", 32'hC0A8_0110 + 32'(k), 32'hC0A8_0110 + 32'(k),
                    mac_base + 48'(16 + k), 1'b0, mac_base + 48'(16 + k));
        end
        resolve("relearn_hit", 32'hC0A8_0114, 32'hC0A8_0114, mac_base + 48'd20, 1'b1,
                mac_base + 48'd20);

        // Reset while waiting for a reply.
        q0 = q_count;
        send_request(32'hC0A8_0150, acc);
        for (int i = 0; i < 10; i++) begin
            if (q_count != q0) break;
            tick();
        end
        tick(); tick();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_ctrl", {59'd0, arp_request_ready, arp_response_valid, arp_response_error,
                               query_valid, busy}, 64'd0);
        check("mid_rst_data", {16'd0, arp_response_mac}, 64'd0);
        check("mid_rst_qip", {32'd0, query_target_ip}, 64'd0);
        rst = 1'b0;
        tick();
        resolve("post_rst", 32'hC0A8_0114, 32'hC0A8_0114, mac_base + 48'd20, 1'b0,
                mac_base + 48'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
